// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, scan-region type and pixel word layout.
// Used by vga_scan_timing and vga_delay_line.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_e;

  // Field names match the rasterizer's color_t so values can be copied across.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic    de;
    logic    hs;
    logic    vs;
    rgb444_t rgb;
  } pix_word_t;

  function automatic region_e region_decode(input logic [9:0] cnt, input int active,
                                            input int fp, input int sync);
    int c;
    c = int'(cnt);
    if (c < active) return ACTIVE;
    if (c < active + fp) return FP;
    if (c < active + fp + sync) return SYNC;
    return BP;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register with synchronous clear; keeps sync, de and colour
// in lock-step on their way to the VGA pins.
module vga_delay_line #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
    end else if (en) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// Raster scan generator and aligned, blanked VGA pin driver.
// Optional macro VGA_TEST_PATTERN_EN replaces r/g/b_in with 8 colour bars.
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int H_FP            = H_FP_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BP            = H_BP_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int V_FP            = V_FP_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BP            = V_BP_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int PIX_DELAY       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic       frame,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  region_e    h_state_q, h_state_d;
  region_e    v_state_q, v_state_d;
  logic       frame_q, frame_d;

  // Region states are decoded from the next count so they line up with px/py.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    frame_d = 1'b0;
    if (pix_en) begin
      if (h_cnt_q == 10'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == 10'(V_TOTAL - 1)) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      frame_d = (h_cnt_d == '0) && (v_cnt_d == 10'(V_ACTIVE));
    end
    h_state_d = region_decode(h_cnt_d, H_ACTIVE, H_FP, H_SYNC);
    v_state_d = region_decode(v_cnt_d, V_ACTIVE, V_FP, V_SYNC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      h_state_q <= ACTIVE;
      v_state_q <= ACTIVE;
      frame_q   <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      frame_q   <= frame_d;
    end
  end

  assign px    = h_cnt_q;
  assign py    = v_cnt_q;
  assign frame = frame_q;

  rgb444_t pix_rgb;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_sel;

  // Bar order white..black maps to r=~bit1, g=~bit2, b=~bit0 of the bar index.
  always_comb begin
    bar_sel   = 3'(h_cnt_q / 10'(BAR_W));
    pix_rgb.r = {4{~bar_sel[1]}};
    pix_rgb.g = {4{~bar_sel[2]}};
    pix_rgb.b = {4{~bar_sel[0]}};
  end
`else
  always_comb begin
    pix_rgb.r = r_in;
    pix_rgb.g = g_in;
    pix_rgb.b = b_in;
  end
`endif

  pix_word_t pipe_in, pipe_out;

  always_comb begin
    pipe_in.de  = (h_state_q == ACTIVE) && (v_state_q == ACTIVE);
    pipe_in.hs  = (h_state_q == SYNC);
    pipe_in.vs  = (v_state_q == SYNC);
    pipe_in.rgb = pix_rgb;
  end

  vga_delay_line #(
    .WIDTH($bits(pix_word_t)),
    .DEPTH(PIX_DELAY)
  ) u_delay (
    .clk (clk),
    .en  (pix_en),
    .clr (rst),
    .din (pipe_in),
    .dout(pipe_out)
  );

  assign vga_de = pipe_out.de;
  assign vga_r  = pipe_out.de ? pipe_out.rgb.r : 4'h0;
  assign vga_g  = pipe_out.de ? pipe_out.rgb.g : 4'h0;
  assign vga_b  = pipe_out.de ? pipe_out.rgb.b : 4'h0;
  assign vga_hs = pipe_out.hs ^ SYNC_ACTIVE_LOW;
  assign vga_vs = pipe_out.vs ^ SYNC_ACTIVE_LOW;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboard bench: a full-size 640x480 instance and a tiny-timing instance
// (PIX_DELAY=3, active-high sync) checked against an arithmetic raster model.
module tb_vga_scan_timing;

  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic       frame;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } obs_t;

  localparam int HA  [2] = '{640, 16};
  localparam int HFP [2] = '{16, 2};
  localparam int HS  [2] = '{96, 3};
  localparam int HB  [2] = '{48, 3};
  localparam int VA  [2] = '{480, 8};
  localparam int VFP [2] = '{10, 1};
  localparam int VS  [2] = '{2, 2};
  localparam int VB  [2] = '{33, 2};
  localparam int DLY [2] = '{1, 3};
  localparam bit SAL [2] = '{1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst, pix_en;
  logic [3:0] r_in, g_in, b_in;

  logic [9:0] px0, py0, px1, py1;
  logic       frame0, frame1;
  logic [3:0] vr0, vg0, vb0, vr1, vg1, vb1;
  logic       hs0, vs0, de0, hs1, vs1, de1;
  obs_t       obs0, obs1;

  int         checks = 0;
  int         errors = 0;
  int         ticks [2];
  logic [11:0] col_hist [2][8];
  obs_t       last_exp [2];
  obs_t       exp_q0 [$];
  obs_t       exp_q1 [$];

  always #5 clk = ~clk;

  vga_scan_timing u_dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .px(px0), .py(py0), .frame(frame0),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .vga_r(vr0), .vga_g(vg0), .vga_b(vb0),
    .vga_hs(hs0), .vga_vs(vs0), .vga_de(de0)
  );

  vga_scan_timing #(
    .H_ACTIVE(HA[1]), .H_FP(HFP[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VFP[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
    .SYNC_ACTIVE_LOW(SAL[1]), .PIX_DELAY(DLY[1])
  ) u_dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .px(px1), .py(py1), .frame(frame1),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .vga_r(vr1), .vga_g(vg1), .vga_b(vb1),
    .vga_hs(hs1), .vga_vs(vs1), .vga_de(de1)
  );

  assign obs0 = {px0, py0, frame0, vr0, vg0, vb0, hs0, vs0, de0};
  assign obs1 = {px1, py1, frame1, vr1, vg1, vb1, hs1, vs1, de1};

  function automatic int h_tot(int inst);
    return HA[inst] + HFP[inst] + HS[inst] + HB[inst];
  endfunction

  function automatic int v_tot(int inst);
    return VA[inst] + VFP[inst] + VS[inst] + VB[inst];
  endfunction

  function automatic logic [11:0] colour_for(int inst, int pos, logic [3:0] r,
                                             logic [3:0] g, logic [3:0] b);
`ifdef VGA_TEST_PATTERN_EN
    int bar;
    bar = (pos % h_tot(inst)) / (HA[inst] / 8);
    case (bar)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
`else
    return {r, g, b};
`endif
  endfunction

  function automatic obs_t reset_obs(int inst);
    obs_t o;
    o    = '0;
    o.hs = SAL[inst];
    o.vs = SAL[inst];
    return o;
  endfunction

  // Expected pins after m ticks: scan position m, pins showing position m-DLY.
  function automatic obs_t model_after(int inst, int m);
    obs_t o;
    int ht, ft, pos, p, h, v;
    logic [11:0] c;
    ht = h_tot(inst);
    ft = ht * v_tot(inst);
    pos = m % ft;
    o = reset_obs(inst);
    o.px = 10'(pos % ht);
    o.py = 10'(pos / ht);
    o.frame = (pos == VA[inst] * ht);
    if (m >= DLY[inst]) begin
      p = (m - DLY[inst]) % ft;
      h = p % ht;
      v = p / ht;
      c = col_hist[inst][(m - DLY[inst]) % 8];
      o.de = (h < HA[inst]) && (v < VA[inst]);
      o.hs = ((h >= HA[inst] + HFP[inst]) && (h < HA[inst] + HFP[inst] + HS[inst])) ^ SAL[inst];
      o.vs = ((v >= VA[inst] + VFP[inst]) && (v < VA[inst] + VFP[inst] + VS[inst])) ^ SAL[inst];
      o.r = o.de ? c[11:8] : 4'h0;
      o.g = o.de ? c[7:4]  : 4'h0;
      o.b = o.de ? c[3:0]  : 4'h0;
    end
    return o;
  endfunction

  task automatic applyStimulus(input bit en, input bit do_rst);
    obs_t e;
    #1;
    pix_en = en;
    rst    = do_rst;
    r_in   = 4'($urandom);
    g_in   = 4'($urandom);
    b_in   = 4'($urandom);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (do_rst) begin
        ticks[i] = 0;
        e = reset_obs(i);
      end else if (en) begin
        col_hist[i][ticks[i] % 8] = colour_for(i, ticks[i] % (h_tot(i) * v_tot(i)), r_in, g_in, b_in);
        ticks[i]++;
        e = model_after(i, ticks[i]);
      end else begin
        e = last_exp[i];
        e.frame = 1'b0;
      end
      last_exp[i] = e;
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got px=%0d py=%0d frame=%b rgb=%h%h%h hs=%b vs=%b de=%b, expected px=%0d py=%0d frame=%b rgb=%h%h%h hs=%b vs=%b de=%b",
               name, act.px, act.py, act.frame, act.r, act.g, act.b, act.hs, act.vs, act.de,
               exp.px, exp.py, exp.frame, exp.r, exp.g, exp.b, exp.hs, exp.vs, exp.de);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q0.size() > 0) checkOutput("dut_a", obs0, exp_q0.pop_front());
    if (exp_q1.size() > 0) checkOutput("dut_b", obs1, exp_q1.pop_front());
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    r_in   = '0;
    g_in   = '0;
    b_in   = '0;
    repeat (3) applyStimulus(1'b1, 1'b1);
    // Two full lines of the 640x480 instance and many tiny frames.
    repeat (2000) applyStimulus(1'b1, 1'b0);
    repeat (3000) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
    // Half-rate enable with resets landing mid-line, once on an idle cycle.
    for (int i = 0; i < 1500; i++) applyStimulus(i % 2 == 0, (i == 907) || (i == 1200));
    repeat (1000) applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d/%0d pending expected 0/0",
               exp_q0.size(), exp_q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
